// File: rtl/lagarto_regfile_rr_if.sv
// lagarto_regfile_rr_if: operand-read bus between the issue logic and the register file.
//   master drives: lock, flush, rd_en, rs1/rs2/rd addresses, rd_writes, writeback (wb_en/wb_addr/wb_data)
//   slave drives:  src1_data/src2_data (registered operands), hazard_stall, pending scoreboard
interface lagarto_regfile_rr_if #(
  parameter int DATA_W = 64,
  parameter int NREG = 32,
  parameter int AW = 5
);
  logic lock;
  logic flush;
  logic rd_en;
  logic rd_writes;
  logic wb_en;
  logic [AW-1:0] rs1_addr;
  logic [AW-1:0] rs2_addr;
  logic [AW-1:0] rd_addr;
  logic [AW-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic [DATA_W-1:0] src1_data;
  logic [DATA_W-1:0] src2_data;
  logic hazard_stall;
  logic [NREG-1:0] pending;
  modport master (
    output lock, flush, rd_en, rd_writes, wb_en, rs1_addr, rs2_addr, rd_addr, wb_addr, wb_data,
    input src1_data, src2_data, hazard_stall, pending
  );
  modport slave (
    input lock, flush, rd_en, rd_writes, wb_en, rs1_addr, rs2_addr, rd_addr, wb_addr, wb_data,
    output src1_data, src2_data, hazard_stall, pending
  );
endinterface

// File: rtl/lagarto_regfile_rr.sv
// lagarto_regfile_rr: integer register file and RR-stage operand read with WB forwarding and RAW/WAW scoreboard.
//   CLK  clock
//   RST  synchronous, active-low reset
//   bus  slave side of lagarto_regfile_rr_if (operand addresses, writeback, registered operands, stall, pending)
module lagarto_regfile_rr #(
  parameter int DATA_W = 64,
  parameter int NREG = 32,
  parameter int AW = 5
) (
  input logic CLK,
  input logic RST,
  lagarto_regfile_rr_if.slave bus
);
  logic [DATA_W-1:0] r_mem [NREG];
  logic [AW-1:0] r_rs1_q, r_rs2_q;
  logic [DATA_W-1:0] r_src1, r_src2;
  logic [NREG-1:0] r_pending;
  logic w_wb1, w_wb2, w_wbq1, w_wbq2, w_hit1, w_hit2, w_waw, w_stall, w_issue;
  logic [DATA_W-1:0] w_rd1, w_rd2;
  logic [NREG-1:0] w_set, w_clr;
  always_comb begin
    w_wb1 = bus.wb_en && bus.wb_addr == bus.rs1_addr;
    w_wb2 = bus.wb_en && bus.wb_addr == bus.rs2_addr;
    // a writer retiring this cycle is forwarded, so it never stalls a reader
    w_hit1 = bus.rs1_addr != '0 && r_pending[bus.rs1_addr] && !w_wb1;
    w_hit2 = bus.rs2_addr != '0 && r_pending[bus.rs2_addr] && !w_wb2;
    w_waw = bus.rd_writes && bus.rd_addr != '0 && r_pending[bus.rd_addr];
    w_stall = bus.rd_en && (w_hit1 || w_hit2 || w_waw);
    w_issue = bus.rd_en && bus.rd_writes && !bus.lock && !bus.flush && !w_stall && bus.rd_addr != '0;
    w_rd1 = bus.rs1_addr == '0 ? '0 : w_wb1 ? bus.wb_data : r_mem[bus.rs1_addr];
    w_rd2 = bus.rs2_addr == '0 ? '0 : w_wb2 ? bus.wb_data : r_mem[bus.rs2_addr];
    // while locked, refresh a held operand whose register is being written back
    w_wbq1 = bus.wb_en && bus.wb_addr == r_rs1_q && r_rs1_q != '0;
    w_wbq2 = bus.wb_en && bus.wb_addr == r_rs2_q && r_rs2_q != '0;
    w_set = w_issue ? NREG'(1) << bus.rd_addr : '0;
    w_clr = bus.wb_en ? NREG'(1) << bus.wb_addr : '0;
  end
  assign bus.src1_data = r_src1;
  assign bus.src2_data = r_src2;
  assign bus.hazard_stall = w_stall;
  assign bus.pending = r_pending;
  always_ff @(posedge CLK) begin
    if (!RST) begin
      for (int i = 0; i < NREG; i++) r_mem[i] <= '0;
      r_rs1_q <= '0;
      r_rs2_q <= '0;
      r_src1 <= '0;
      r_src2 <= '0;
      r_pending <= '0;
    end else begin
      if (bus.wb_en && bus.wb_addr != '0) r_mem[bus.wb_addr] <= bus.wb_data;
      if (bus.flush) begin
        r_rs1_q <= '0;
        r_rs2_q <= '0;
        r_src1 <= '0;
        r_src2 <= '0;
        r_pending <= '0;
      end else begin
        // set after clear so a same-cycle issue wins over a retiring writer
        r_pending <= (r_pending & ~w_clr) | w_set;
        if (bus.lock) begin
          r_src1 <= w_wbq1 ? bus.wb_data : r_src1;
          r_src2 <= w_wbq2 ? bus.wb_data : r_src2;
        end else begin
          r_rs1_q <= bus.rs1_addr;
          r_rs2_q <= bus.rs2_addr;
          r_src1 <= w_rd1;
          r_src2 <= w_rd2;
        end
      end
    end
  end
endmodule

// File: tb/tb_lagarto_regfile_rr.sv
// tb_lagarto_regfile_rr: scoreboard bench for lagarto_regfile_rr; expected operands queued at drive time, popped after each edge.
module tb_lagarto_regfile_rr;
  logic CLK = 1'b0;
  logic RST;
  int checks = 0;
  int failures = 0;
  logic [63:0] q1 [$];
  logic [63:0] q2 [$];
  always #5 CLK = ~CLK;
  lagarto_regfile_rr_if #(.DATA_W(64), .NREG(32), .AW(5)) bus ();
  lagarto_regfile_rr #(.DATA_W(64), .NREG(32), .AW(5)) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus.slave)
  );

  task automatic idle();
    bus.lock = 0; bus.flush = 0; bus.rd_en = 0; bus.rd_writes = 0; bus.wb_en = 0;
    bus.rs1_addr = 0; bus.rs2_addr = 0; bus.rd_addr = 0; bus.wb_addr = 0; bus.wb_data = 0;
  endtask

  task automatic wb(input logic [4:0] a, input logic [63:0] d);
    bus.wb_en = 1; bus.wb_addr = a; bus.wb_data = d;
  endtask

  task automatic push(input logic [63:0] e1, input logic [63:0] e2);
    q1.push_back(e1);
    q2.push_back(e2);
  endtask

  task automatic step();
    logic [63:0] e1, e2;
    @(posedge CLK);
    @(negedge CLK);
    if (q1.size() > 0) begin
      e1 = q1.pop_front();
      e2 = q2.pop_front();
      checks++;
      if (bus.src1_data !== e1) begin
        failures++;
        $display("FAIL sb_src1 t=%0t got=%h exp=%h", $time, bus.src1_data, e1);
      end
      checks++;
      if (bus.src2_data !== e2) begin
        failures++;
        $display("FAIL sb_src2 t=%0t got=%h exp=%h", $time, bus.src2_data, e2);
      end
    end
  endtask

  task automatic chk_pend(input string n, input logic [31:0] e);
    checks++;
    if (bus.pending !== e) begin
      failures++;
      $display("FAIL %s pending got=%h exp=%h", n, bus.pending, e);
    end
  endtask

  task automatic chk_stall(input string n, input logic e);
    #1;
    checks++;
    if (bus.hazard_stall !== e) begin
      failures++;
      $display("FAIL %s stall got=%b exp=%b", n, bus.hazard_stall, e);
    end
  endtask

  task automatic test_reset();
    RST = 0;
    idle();
    step();
    step();
    checks++;
    if (bus.src1_data !== 64'd0 || bus.src2_data !== 64'd0) begin
      failures++;
      $display("FAIL reset_src got=%h/%h exp=0/0", bus.src1_data, bus.src2_data);
    end
    chk_pend("reset", 32'h0);
    chk_stall("reset", 1'b0);
    RST = 1;
    bus.rs1_addr = 5; bus.rs2_addr = 0;
    push(64'd0, 64'd0);
    step();
    chk_pend("after_reset", 32'h0);
  endtask

  task automatic test_forward();
    idle();
    wb(5, 64'hDEAD_BEEF);
    bus.rs1_addr = 5; bus.rs2_addr = 6;
    push(64'hDEAD_BEEF, 64'd0);
    step();
    bus.wb_en = 0;
    bus.rs1_addr = 6; bus.rs2_addr = 5;
    push(64'd0, 64'hDEAD_BEEF);
    step();
    wb(6, 64'h1234);
    bus.rs1_addr = 5; bus.rs2_addr = 0;
    push(64'hDEAD_BEEF, 64'd0);
    step();
    idle();
    bus.rs1_addr = 6; bus.rs2_addr = 6;
    push(64'h1234, 64'h1234);
    step();
  endtask

  task automatic test_lock();
    idle();
    wb(7, 64'h11);
    push(64'd0, 64'd0);
    step();
    bus.wb_en = 0;
    bus.rs2_addr = 7;
    push(64'd0, 64'h11);
    step();
    bus.lock = 1;
    bus.rs2_addr = 3;
    wb(8, 64'h88);
    push(64'd0, 64'h11);
    step();
    wb(7, 64'h22);
    push(64'd0, 64'h22);
    step();
    bus.wb_en = 0;
    push(64'd0, 64'h22);
    step();
    bus.lock = 0;
    bus.rs1_addr = 8; bus.rs2_addr = 7;
    push(64'h88, 64'h22);
    step();
  endtask

  task automatic test_hazard();
    idle();
    bus.rd_en = 1; bus.rd_writes = 1; bus.rd_addr = 9;
    chk_stall("issue9", 1'b0);
    push(64'd0, 64'd0);
    step();
    chk_pend("issue9", 32'h200);
    bus.rd_writes = 0; bus.rs1_addr = 9;
    chk_stall("raw9", 1'b1);
    push(64'd0, 64'd0);
    step();
    chk_pend("raw9_hold", 32'h200);
    wb(9, 64'h99);
    chk_stall("raw9_wb", 1'b0);
    push(64'h99, 64'd0);
    step();
    chk_pend("raw9_clr", 32'h0);
    bus.wb_en = 0; bus.rs1_addr = 0;
    bus.rd_writes = 1; bus.rd_addr = 10;
    push(64'd0, 64'd0);
    step();
    chk_pend("issue10", 32'h400);
    wb(10, 64'hAA);
    chk_stall("waw10", 1'b1);
    push(64'd0, 64'd0);
    step();
    chk_pend("waw10_blocked", 32'h0);
    bus.wb_en = 0; bus.rd_addr = 11;
    push(64'd0, 64'd0);
    step();
    chk_pend("issue11", 32'h800);
    bus.rd_writes = 0; bus.rs2_addr = 11;
    chk_stall("raw11_rs2", 1'b1);
    push(64'd0, 64'd0);
    step();
  endtask

  task automatic test_flush();
    idle();
    bus.rd_en = 1; bus.rd_writes = 1; bus.rd_addr = 3;
    bus.rs1_addr = 5; bus.rs2_addr = 6;
    chk_stall("issue3", 1'b0);
    push(64'hDEAD_BEEF, 64'h1234);
    step();
    chk_pend("issue3", 32'h808);
    bus.flush = 1; bus.lock = 1; bus.rd_addr = 12;
    wb(13, 64'h1313);
    push(64'd0, 64'd0);
    step();
    chk_pend("flush", 32'h0);
    idle();
    bus.rs1_addr = 13; bus.rs2_addr = 5;
    push(64'h1313, 64'hDEAD_BEEF);
    step();
  endtask

  task automatic test_zero();
    idle();
    wb(0, 64'hFFFF);
    push(64'd0, 64'd0);
    step();
    chk_pend("wb_x0", 32'h0);
    bus.rd_en = 1; bus.rd_writes = 1; bus.rd_addr = 4;
    wb(4, 64'h44);
    chk_stall("setclr4", 1'b0);
    push(64'd0, 64'd0);
    step();
    chk_pend("setclr4", 32'h10);
    idle();
    wb(4, 64'h55);
    bus.rs1_addr = 4;
    push(64'h55, 64'd0);
    step();
    chk_pend("clr4", 32'h0);
    idle();
    bus.rd_en = 1; bus.rd_writes = 1; bus.rd_addr = 0;
    bus.rs1_addr = 4;
    push(64'h55, 64'd0);
    step();
    chk_pend("rd_x0", 32'h0);
  endtask

  task automatic test_back_to_back();
    idle();
    for (int i = 1; i < 8; i++) begin
      wb(5'(16 + i), 64'(i) * 64'h0101_0101);
      bus.rs1_addr = 5'(16 + i);
      bus.rs2_addr = 5'(15 + i);
      push(64'(i) * 64'h0101_0101, i == 1 ? 64'd0 : 64'(i - 1) * 64'h0101_0101);
      step();
    end
    idle();
    step();
  endtask

  initial begin
    test_reset();
    test_forward();
    test_lock();
    test_hazard();
    test_flush();
    test_zero();
    test_back_to_back();
    checks++;
    if (q1.size() != 0) begin
      failures++;
      $display("FAIL sb_drain left=%0d exp=0", q1.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
